lsu_port: RTL and testbench

Load/store port that sits directly upstream of the byte-addressable data RAM. It accepts one memory request at a time from the execute stage over a valid/ready handshake, translates RISC-V funct3 access types into the RAM's `read_ctrl`/`write_ctrl` encodings, and performs bounds checking. It captures load data and returns one response per request, with an error flag, over a second valid/ready handshake.

---
 rtl/lsu_port.sv | 235 +++++++++++++++++++++++
 tb/tb_lsu_port.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_port.sv
// lsu_port: single-outstanding load/store port in front of the byte-addressable
// data RAM. Requests are accepted over one valid/ready handshake, translated
// into the RAM's read_ctrl/write_ctrl codes, bounds-checked, and answered with
// one response (data + error flag) over a second valid/ready handshake.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds valid and its payload
// stable until that edge. The consumer may raise or drop ready freely. Here
// req_ready is high only in IDLE, and resp_valid is high only in RESP.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, a halfword
// access with addr[0]=1 or a word access with addr[1:0]!=0 is rejected with
// err and makes no RAM access. When it is undefined, misaligned accesses pass
// to the RAM unchanged.
//
// The FSM state is visible on the internal 'state' signal for checkers.

module lsu_port #(
    parameter int unsigned MEM_SIZE = 4194304
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [1:0]  ram_write_ctrl,
    output logic [2:0]  ram_read_ctrl,
    input  logic [31:0] ram_rdata
);

    // RISC-V funct3 access types
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // RAM write_ctrl encodings
    localparam logic [1:0] WC_NONE = 2'b00;
    localparam logic [1:0] WC_HALF = 2'b01;
    localparam logic [1:0] WC_BYTE = 2'b10;
    localparam logic [1:0] WC_WORD = 2'b11;

    // RAM read_ctrl encodings
    localparam logic [2:0] RC_NONE = 3'b000;
    localparam logic [2:0] RC_LW   = 3'b001;
    localparam logic [2:0] RC_LHU  = 3'b010;
    localparam logic [2:0] RC_LH   = 3'b011;
    localparam logic [2:0] RC_LBU  = 3'b100;
    localparam logic [2:0] RC_LB   = 3'b101;

    // 33-bit limit so that addr + size never wraps
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Request fields latched at acceptance
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;

    // Response registers, written at the edge that closes ISSUE
    logic [31:0] rdata_q;
    logic        resp_err_q;

    // Acceptance-time decode
    logic        accept;
    logic [2:0]  acc_size;
    logic        size_ok;
    logic [32:0] end_addr;
    logic        range_err;
    logic        misalign_err;
    logic        req_err;

    // ISSUE-time mapping
    logic        issue_ok;
    logic [1:0]  write_code;
    logic [2:0]  read_code;
    logic [31:0] load_ext;

    assign accept = req_valid && (state == IDLE);

    // Decode access size from funct3/we and flag illegal, out-of-range or misaligned requests
    always_comb begin
        acc_size = 3'd0;
        size_ok  = 1'b0;
        case (req_funct3)
            F3_B:  begin acc_size = 3'd1; size_ok = 1'b1; end
            F3_H:  begin acc_size = 3'd2; size_ok = 1'b1; end
            F3_W:  begin acc_size = 3'd4; size_ok = 1'b1; end
            F3_BU: begin acc_size = 3'd1; size_ok = !req_we; end
            F3_HU: begin acc_size = 3'd2; size_ok = !req_we; end
            default: begin acc_size = 3'd0; size_ok = 1'b0; end
        endcase
        end_addr  = {1'b0, req_addr} + {30'd0, acc_size};
        range_err = (end_addr > MEM_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_err = ((acc_size == 3'd2) && req_addr[0]) ||
                       ((acc_size == 3'd4) && (req_addr[1:0] != 2'b00));
`else
        misalign_err = 1'b0;
`endif
        req_err = !size_ok || range_err || misalign_err;
    end

    // Latch the request and its error verdict when it is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Map the latched funct3 to RAM control codes
    always_comb begin
        write_code = WC_NONE;
        read_code  = RC_NONE;
        case (funct3_q)
            F3_B:  begin write_code = WC_BYTE; read_code = RC_LB;  end
            F3_H:  begin write_code = WC_HALF; read_code = RC_LH;  end
            F3_W:  begin write_code = WC_WORD; read_code = RC_LW;  end
            F3_BU: begin write_code = WC_NONE; read_code = RC_LBU; end
            F3_HU: begin write_code = WC_NONE; read_code = RC_LHU; end
            default: begin write_code = WC_NONE; read_code = RC_NONE; end
        endcase
    end

    // RAM controls are live only during an error-free ISSUE cycle
    always_comb begin
        issue_ok       = (state == ISSUE) && !err_q;
        ram_write_ctrl = WC_NONE;
        ram_read_ctrl  = RC_NONE;
        if (issue_ok) begin
            if (we_q) begin
                ram_write_ctrl = write_code;
            end else begin
                ram_read_ctrl = read_code;
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    // Extend the RAM data by access type; idempotent if the RAM already extended it
    always_comb begin
        load_ext = 32'h0;
        case (funct3_q)
            F3_B:  load_ext = {{24{ram_rdata[7]}}, ram_rdata[7:0]};
            F3_H:  load_ext = {{16{ram_rdata[15]}}, ram_rdata[15:0]};
            F3_W:  load_ext = ram_rdata;
            F3_BU: load_ext = {24'h0, ram_rdata[7:0]};
            F3_HU: load_ext = {16'h0, ram_rdata[15:0]};
            default: load_ext = 32'h0;
        endcase
    end

    // Capture the response at the edge closing ISSUE; stores and errors return zero data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q    <= 32'h0;
            resp_err_q <= 1'b0;
        end else if (state == ISSUE) begin
            resp_err_q <= err_q;
            rdata_q    <= (err_q || we_q) ? 32'h0 : load_ext;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_port.sv
// Directed testbench for lsu_port with a small little-endian RAM model.
module tb_lsu_port;

    localparam int unsigned MEM = 4194304;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [1:0]  ram_write_ctrl;
    logic [2:0]  ram_read_ctrl;
    logic [31:0] ram_rdata;

    int chk_cnt = 0;
    int pass_cnt = 0;

    // Results of the last transaction
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [1:0]  wci;
    logic [2:0]  rci;
    int          wcn;

    // Clock
    always #5 clk = ~clk;

    lsu_port #(.MEM_SIZE(MEM)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_write_ctrl (ram_write_ctrl),
        .ram_read_ctrl  (ram_read_ctrl),
        .ram_rdata      (ram_rdata)
    );

    // RAM model: 4 KiB window, address aliased on the low 12 bits
    logic [7:0]  mem [0:4095];
    logic [11:0] a0, a1, a2, a3;
    assign a0 = ram_addr[11:0];
    assign a1 = a0 + 12'd1;
    assign a2 = a0 + 12'd2;
    assign a3 = a0 + 12'd3;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end else begin
            case (ram_write_ctrl)
                2'b11: begin
                    mem[a0] <= ram_wdata[7:0];   mem[a1] <= ram_wdata[15:8];
                    mem[a2] <= ram_wdata[23:16]; mem[a3] <= ram_wdata[31:24];
                end
                2'b01: begin mem[a0] <= ram_wdata[7:0]; mem[a1] <= ram_wdata[15:8]; end
                2'b10: mem[a0] <= ram_wdata[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_rdata = 32'h0;
        case (ram_read_ctrl)
            3'b001: ram_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
            3'b010: ram_rdata = {16'h0, mem[a1], mem[a0]};
            3'b011: ram_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b100: ram_rdata = {24'h0, mem[a0]};
            3'b101: ram_rdata = {{24{mem[a0][7]}}, mem[a0]};
            default: ram_rdata = 32'h0;
        endcase
    end

    // Driver: one full request/response with resp_ready held high
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] o_rd, output logic o_er,
                        output int o_lat, output logic [1:0] o_wci, output logic [2:0] o_rci,
                        output int o_wcn);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        o_wci = ram_write_ctrl; o_rci = ram_read_ctrl;
        o_lat = 1; o_wcn = 0;
        if (ram_write_ctrl != 2'b00) o_wcn++;
        while (!resp_valid && o_lat < 20) begin
            @(negedge clk);
            o_lat++;
            if (ram_write_ctrl != 2'b00) o_wcn++;
        end
        o_rd = resp_rdata; o_er = resp_err;
        @(negedge clk);
        if (ram_write_ctrl != 2'b00) o_wcn++;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        #1;
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b exp=1", req_ready); else pass_cnt++;
        chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); else pass_cnt++;
        chk_cnt++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata got=%h exp=0", resp_rdata); else pass_cnt++;
        chk_cnt++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err got=%b exp=0", resp_err); else pass_cnt++;
        chk_cnt++; if (ram_addr !== 32'h0) $display("FAIL rst_ram_addr got=%h exp=0", ram_addr); else pass_cnt++;
        chk_cnt++; if (ram_wdata !== 32'h0) $display("FAIL rst_ram_wdata got=%h exp=0", ram_wdata); else pass_cnt++;
        chk_cnt++; if (ram_write_ctrl !== 2'b00) $display("FAIL rst_wctrl got=%b exp=00", ram_write_ctrl); else pass_cnt++;
        chk_cnt++; if (ram_read_ctrl !== 3'b000) $display("FAIL rst_rctrl got=%b exp=000", ram_read_ctrl); else pass_cnt++;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load;
        xact(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (wci !== 2'b11) $display("FAIL sw_wctrl got=%b exp=11", wci); else pass_cnt++;
        chk_cnt++; if (wcn !== 1) $display("FAIL sw_wctrl_cycles got=%0d exp=1", wcn); else pass_cnt++;
        chk_cnt++; if (er !== 1'b0) $display("FAIL sw_err got=%b exp=0", er); else pass_cnt++;
        chk_cnt++; if (rd !== 32'h0) $display("FAIL sw_rdata got=%h exp=0", rd); else pass_cnt++;
        chk_cnt++; if (lat !== 2) $display("FAIL sw_latency got=%0d exp=2", lat); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL idle_after_resp got=%b exp=1", req_ready); else pass_cnt++;
        xact(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_rdata got=%h exp=deadbeef", rd); else pass_cnt++;
        chk_cnt++; if (er !== 1'b0) $display("FAIL lw_err got=%b exp=0", er); else pass_cnt++;
        chk_cnt++; if (lat !== 2) $display("FAIL lw_latency got=%0d exp=2", lat); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b001) $display("FAIL lw_rctrl got=%b exp=001", rci); else pass_cnt++;
        chk_cnt++; if (wcn !== 0) $display("FAIL lw_no_write got=%0d exp=0", wcn); else pass_cnt++;
    endtask

    task automatic test_extension;
        xact(1'b1, 3'b000, 32'h200, 32'h12345680, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (wci !== 2'b10) $display("FAIL sb_wctrl got=%b exp=10", wci); else pass_cnt++;
        xact(1'b0, 3'b000, 32'h200, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_rdata got=%h exp=ffffff80", rd); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b101) $display("FAIL lb_rctrl got=%b exp=101", rci); else pass_cnt++;
        xact(1'b0, 3'b100, 32'h200, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (rd !== 32'h00000080) $display("FAIL lbu_rdata got=%h exp=00000080", rd); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b100) $display("FAIL lbu_rctrl got=%b exp=100", rci); else pass_cnt++;
        xact(1'b1, 3'b001, 32'h210, 32'hABCD8001, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (wci !== 2'b01) $display("FAIL sh_wctrl got=%b exp=01", wci); else pass_cnt++;
        xact(1'b0, 3'b001, 32'h210, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (rd !== 32'hFFFF8001) $display("FAIL lh_rdata got=%h exp=ffff8001", rd); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b011) $display("FAIL lh_rctrl got=%b exp=011", rci); else pass_cnt++;
        xact(1'b0, 3'b101, 32'h210, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (rd !== 32'h00008001) $display("FAIL lhu_rdata got=%h exp=00008001", rd); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b010) $display("FAIL lhu_rctrl got=%b exp=010", rci); else pass_cnt++;
    endtask

    task automatic test_bounds;
        xact(1'b1, 3'b010, MEM - 32'd4, 32'hCAFEF00D, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b0) $display("FAIL sw_top_err got=%b exp=0", er); else pass_cnt++;
        xact(1'b0, 3'b010, MEM - 32'd4, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b0) $display("FAIL lw_top_err got=%b exp=0", er); else pass_cnt++;
        chk_cnt++; if (rd !== 32'hCAFEF00D) $display("FAIL lw_top_rdata got=%h exp=cafef00d", rd); else pass_cnt++;
        xact(1'b0, 3'b010, MEM - 32'd3, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b1) $display("FAIL lw_over_err got=%b exp=1", er); else pass_cnt++;
        chk_cnt++; if (rd !== 32'h0) $display("FAIL lw_over_rdata got=%h exp=0", rd); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b000) $display("FAIL lw_over_rctrl got=%b exp=000", rci); else pass_cnt++;
        chk_cnt++; if (lat !== 2) $display("FAIL lw_over_latency got=%0d exp=2", lat); else pass_cnt++;
        xact(1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b1) $display("FAIL lw_wrap_err got=%b exp=1", er); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b000) $display("FAIL lw_wrap_rctrl got=%b exp=000", rci); else pass_cnt++;
        xact(1'b1, 3'b000, MEM - 32'd1, 32'h5A, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b0) $display("FAIL sb_last_err got=%b exp=0", er); else pass_cnt++;
        chk_cnt++; if (wci !== 2'b10) $display("FAIL sb_last_wctrl got=%b exp=10", wci); else pass_cnt++;
        xact(1'b1, 3'b001, MEM - 32'd1, 32'h5A5A, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b1) $display("FAIL sh_over_err got=%b exp=1", er); else pass_cnt++;
        chk_cnt++; if (wcn !== 0) $display("FAIL sh_over_no_write got=%0d exp=0", wcn); else pass_cnt++;
    endtask

    task automatic test_invalid_funct3;
        xact(1'b0, 3'b011, 32'h100, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b1) $display("FAIL ld011_err got=%b exp=1", er); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b000) $display("FAIL ld011_rctrl got=%b exp=000", rci); else pass_cnt++;
        chk_cnt++; if (rd !== 32'h0) $display("FAIL ld011_rdata got=%h exp=0", rd); else pass_cnt++;
        xact(1'b1, 3'b100, 32'h100, 32'h11111111, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b1) $display("FAIL st100_err got=%b exp=1", er); else pass_cnt++;
        chk_cnt++; if (wcn !== 0) $display("FAIL st100_no_write got=%0d exp=0", wcn); else pass_cnt++;
        xact(1'b1, 3'b101, 32'h100, 32'h22222222, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b1) $display("FAIL st101_err got=%b exp=1", er); else pass_cnt++;
        chk_cnt++; if (wcn !== 0) $display("FAIL st101_no_write got=%0d exp=0", wcn); else pass_cnt++;
        xact(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL word_intact got=%h exp=deadbeef", rd); else pass_cnt++;
    endtask

    task automatic test_misalign;
        xact(1'b1, 3'b010, 32'h104, 32'h44332211, rd, er, lat, wci, rci, wcn);
        chk_cnt++; if (er !== 1'b0) $display("FAIL sw104_err got=%b exp=0", er); else pass_cnt++;
        xact(1'b0, 3'b010, 32'h102, 32'h0, rd, er, lat, wci, rci, wcn);
`ifdef LSU_MISALIGN_TRAP_EN
        chk_cnt++; if (er !== 1'b1) $display("FAIL lw102_err got=%b exp=1", er); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b000) $display("FAIL lw102_rctrl got=%b exp=000", rci); else pass_cnt++;
        chk_cnt++; if (rd !== 32'h0) $display("FAIL lw102_rdata got=%h exp=0", rd); else pass_cnt++;
`else
        chk_cnt++; if (er !== 1'b0) $display("FAIL lw102_err got=%b exp=0", er); else pass_cnt++;
        chk_cnt++; if (rci !== 3'b001) $display("FAIL lw102_rctrl got=%b exp=001", rci); else pass_cnt++;
        chk_cnt++; if (rd !== 32'h2211DEAD) $display("FAIL lw102_rdata got=%h exp=2211dead", rd); else pass_cnt++;
`endif
        xact(1'b0, 3'b001, 32'h101, 32'h0, rd, er, lat, wci, rci, wcn);
`ifdef LSU_MISALIGN_TRAP_EN
        chk_cnt++; if (er !== 1'b1) $display("FAIL lh101_err got=%b exp=1", er); else pass_cnt++;
        chk_cnt++; if (rd !== 32'h0) $display("FAIL lh101_rdata got=%h exp=0", rd); else pass_cnt++;
`else
        chk_cnt++; if (er !== 1'b0) $display("FAIL lh101_err got=%b exp=0", er); else pass_cnt++;
        chk_cnt++; if (rd !== 32'hFFFFADBE) $display("FAIL lh101_rdata got=%h exp=ffffadbe", rd); else pass_cnt++;
`endif
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        req_wdata = 32'h0; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // a second load waits while the first is outstanding
        req_addr = 32'h104;
        n = 0;
        while (!resp_valid && n < 10) begin @(negedge clk); n++; end
        chk_cnt++; if (n !== 1) $display("FAIL bp_resp_arrival got=%0d exp=1", n); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (resp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got=%b exp=1", i, resp_valid); else pass_cnt++;
            chk_cnt++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL bp_rdata[%0d] got=%h exp=deadbeef", i, resp_rdata); else pass_cnt++;
            chk_cnt++; if (resp_err !== 1'b0) $display("FAIL bp_err[%0d] got=%b exp=0", i, resp_err); else pass_cnt++;
            chk_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, req_ready); else pass_cnt++;
            @(negedge clk);
        end
        chk_cnt++; if (ram_read_ctrl !== 3'b000) $display("FAIL bp_rctrl got=%b exp=000", ram_read_ctrl); else pass_cnt++;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL bp_idle_ready got=%b exp=1", req_ready); else pass_cnt++;
        chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL bp_idle_valid got=%b exp=0", resp_valid); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_accept_ready got=%b exp=0", req_ready); else pass_cnt++;
        chk_cnt++; if (ram_read_ctrl !== 3'b001) $display("FAIL bp_accept_rctrl got=%b exp=001", ram_read_ctrl); else pass_cnt++;
        chk_cnt++; if (ram_addr !== 32'h104) $display("FAIL bp_accept_addr got=%h exp=00000104", ram_addr); else pass_cnt++;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin @(negedge clk); n++; end
        chk_cnt++; if (resp_rdata !== 32'h44332211) $display("FAIL bp_second_rdata got=%h exp=44332211", resp_rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_issue;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300;
        req_wdata = 32'h11223344; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk_cnt++; if (ram_write_ctrl !== 2'b11) $display("FAIL mid_issue_wctrl got=%b exp=11", ram_write_ctrl); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++; if (ram_write_ctrl !== 2'b00) $display("FAIL arst_wctrl got=%b exp=00", ram_write_ctrl); else pass_cnt++;
        chk_cnt++; if (ram_read_ctrl !== 3'b000) $display("FAIL arst_rctrl got=%b exp=000", ram_read_ctrl); else pass_cnt++;
        chk_cnt++; if (ram_addr !== 32'h0) $display("FAIL arst_ram_addr got=%h exp=0", ram_addr); else pass_cnt++;
        chk_cnt++; if (ram_wdata !== 32'h0) $display("FAIL arst_ram_wdata got=%h exp=0", ram_wdata); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL arst_req_ready got=%b exp=1", req_ready); else pass_cnt++;
        chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL arst_resp_valid got=%b exp=0", resp_valid); else pass_cnt++;
        chk_cnt++; if (resp_rdata !== 32'h0) $display("FAIL arst_resp_rdata got=%h exp=0", resp_rdata); else pass_cnt++;
        chk_cnt++; if (resp_err !== 1'b0) $display("FAIL arst_resp_err got=%b exp=0", resp_err); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_cnt++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready got=%b exp=1", req_ready); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL post_rst_no_resp got=%b exp=0", resp_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_extension;
        test_bounds;
        test_invalid_funct3;
        test_misalign;
        test_backpressure;
        test_reset_mid_issue;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
